// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding and lamp constants for the intersection controller
package traffic_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_NS_GREEN  = 4'd1;
  localparam logic [3:0] ST_NS_YELLOW = 4'd2;
  localparam logic [3:0] ST_ALLRED_1  = 4'd3;
  localparam logic [3:0] ST_EW_GREEN  = 4'd4;
  localparam logic [3:0] ST_EW_YELLOW = 4'd5;
  localparam logic [3:0] ST_ALLRED_2  = 4'd6;
  localparam logic [3:0] ST_PED_WALK  = 4'd7;
  localparam logic [3:0] ST_FLASH     = 4'd8;

  typedef enum logic [3:0] {
    IDLE      = ST_IDLE,
    NS_GREEN  = ST_NS_GREEN,
    NS_YELLOW = ST_NS_YELLOW,
    ALLRED_1  = ST_ALLRED_1,
    EW_GREEN  = ST_EW_GREEN,
    EW_YELLOW = ST_EW_YELLOW,
    ALLRED_2  = ST_ALLRED_2,
    PED_WALK  = ST_PED_WALK,
    FLASH     = ST_FLASH
  } state_t;

  localparam int RED = 2;
  localparam int YEL = 1;
  localparam int GRN = 0;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/traffic_intersection_ctrl_if.sv
// rtl/traffic_intersection_ctrl_if.sv - control inputs and lamp outputs of the intersection controller
interface traffic_intersection_ctrl_if;
  logic       enable;
  logic       flash_mode;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic [3:0] state_o;

  modport master (
    output enable, flash_mode, ped_req,
    input  ns_light, ew_light, walk, ped_pending, state_o
  );

  modport slave (
    input  enable, flash_mode, ped_req,
    output ns_light, ew_light, walk, ped_pending, state_o
  );
endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - phase counter with synchronous clear; done on the last cycle of limit
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic [CNT_W:0] limit,
  output logic           done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = clear ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // limit is one bit wider so a duration of 2**CNT_W still fits
  assign done = ({1'b0, count_q} == limit - (CNT_W+1)'(1));

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - two-approach signal controller with clearance, walk and flash modes
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 70,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 10,
  parameter int FLASH_T  = 8
) (
  input  logic clk,
  input  logic rst_n,
  traffic_intersection_ctrl_if.slave bus
);

  localparam logic [CNT_W:0] LIM_G = (CNT_W+1)'(GREEN_T);
  localparam logic [CNT_W:0] LIM_Y = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0] LIM_A = (CNT_W+1)'(ALLRED_T);
  localparam logic [CNT_W:0] LIM_P = (CNT_W+1)'(PED_T);
  localparam logic [CNT_W:0] LIM_F = (CNT_W+1)'(FLASH_T);

  state_t         state_q, state_d;
  logic           phase_q, phase_d;
  logic           ped_q, ped_d;
  logic           stop, t_done, t_clear;
  logic [CNT_W:0] t_limit;

  assign stop = !bus.enable || bus.flash_mode;

  always_comb begin
    t_limit = (CNT_W+1)'(1);
    unique case (state_q)
      NS_GREEN, EW_GREEN:   t_limit = LIM_G;
      NS_YELLOW, EW_YELLOW: t_limit = LIM_Y;
      ALLRED_1, ALLRED_2:   t_limit = LIM_A;
      PED_WALK:             t_limit = LIM_P;
      FLASH:                t_limit = LIM_F;
      default:              t_limit = (CNT_W+1)'(1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.flash_mode) state_d = FLASH;
                 else if (bus.enable) state_d = NS_GREEN;
      // a stop request shortens green but always passes through yellow
      NS_GREEN:  if (stop || t_done) state_d = NS_YELLOW;
      NS_YELLOW: if (t_done) state_d = ALLRED_1;
      ALLRED_1:  if (t_done) state_d = stop ? IDLE : EW_GREEN;
      EW_GREEN:  if (stop || t_done) state_d = EW_YELLOW;
      EW_YELLOW: if (t_done) state_d = ALLRED_2;
      ALLRED_2:  if (t_done) state_d = stop ? IDLE : (ped_q ? PED_WALK : NS_GREEN);
      PED_WALK:  if (t_done) state_d = stop ? IDLE : NS_GREEN;
      FLASH:     if (!bus.flash_mode) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FLASH reuses the timer as a free-running half-period divider
  assign t_clear = (state_d != state_q) || (state_q == FLASH && t_done);

  always_comb begin
    phase_d = 1'b0;
    if (state_q == FLASH && state_d == FLASH) phase_d = t_done ? !phase_q : phase_q;
  end

  always_comb begin
    ped_d = ped_q;
    if (state_d == PED_WALK || state_q == PED_WALK) ped_d = 1'b0;
    else if (bus.ped_req) ped_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ped_q   <= ped_d;
    end
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (t_clear),
    .limit (t_limit),
    .done  (t_done)
  );

  always_comb begin
    bus.ns_light = LAMP_R;
    bus.ew_light = LAMP_R;
    bus.walk     = 1'b0;
    unique case (state_q)
      NS_GREEN:  bus.ns_light = LAMP_G;
      NS_YELLOW: bus.ns_light = LAMP_Y;
      EW_GREEN:  bus.ew_light = LAMP_G;
      EW_YELLOW: bus.ew_light = LAMP_Y;
      PED_WALK:  bus.walk     = 1'b1;
      FLASH: begin
        bus.ns_light = phase_q ? LAMP_Y : LAMP_OFF;
        bus.ew_light = phase_q ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign bus.ped_pending = ped_q;
  assign bus.state_o     = state_q;

endmodule
